// File: rtl/ror_pkg.sv
// Shared types and constants for the sequential rotate-right unit.
package ror_pkg;
  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/ror_step.sv
// Combinational rotate-right of one word by 0..STEP positions.
module ror_step #(
  parameter int STEP = 4,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [ror_pkg::WIDTH-1:0] d,
  input  logic [KW-1:0]             k,
  output logic [ror_pkg::WIDTH-1:0] q
);
  import ror_pkg::*;

  logic [AMT_W-1:0] idx [WIDTH];

  // Bit index wraps naturally in AMT_W bits, giving (i + k) mod 32.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      idx[i] = AMT_W'(i + int'(k));
      q[i]   = d[idx[i]];
    end
  end
endmodule

// File: rtl/ror32_seq.sv
// Multi-cycle rotate-right, up to STEP positions per clock, start/busy/done handshake.
// Define ROR32_SEQ_DIR_EN to add a dir port (1 = rotate-left).
module ror32_seq #(
  parameter int STEP  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      num_rotate,
`ifdef ROR32_SEQ_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);
  import ror_pkg::*;

  localparam int KW = $clog2(STEP + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] rot;
  logic [AMT_W-1:0] rem, rem_n, rem_load;
  logic [KW-1:0]    k;
  logic [26:0]      unused_rot_hi;

  assign unused_rot_hi = num_rotate[31:5];

`ifdef ROR32_SEQ_DIR_EN
  // Left rotation by n is right rotation by (32 - n) mod 32.
  assign rem_load = dir ? (AMT_W'(0) - num_rotate[4:0]) : num_rotate[4:0];
`else
  assign rem_load = num_rotate[4:0];
`endif

  assign k     = (int'(rem) < STEP) ? KW'(rem) : KW'(STEP);
  assign rem_n = rem - AMT_W'(k);

  ror_step #(.STEP(STEP), .KW(KW)) u_step (
    .d(shreg),
    .k(k),
    .q(rot)
  );

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (rem_load == '0) ? DONE : ROTATE;
      ROTATE:  if (rem_n == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      shreg <= '0;
      rem   <= '0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= in;
            rem   <= rem_load;
            if (rem_load == '0) out <= in;
          end
        end
        ROTATE: begin
          shreg <= rot;
          rem   <= rem_n;
          if (rem_n == '0) out <= rot;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_ror32_seq.sv
// Directed bench for ror32_seq with a scoreboard of expected result and latency.
module tb_ror32_seq;
  localparam int STEP = 4;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in = '0;
  logic [31:0] num_rotate = '0;
`ifdef ROR32_SEQ_DIR_EN
  logic        dir = 1'b0;
`endif
  logic [31:0] out;
  logic        busy;
  logic        done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ror32_seq #(.STEP(STEP), .WIDTH(32)) dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .in(in),
    .num_rotate(num_rotate),
`ifdef ROR32_SEQ_DIR_EN
    .dir(dir),
`endif
    .out(out),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ror_model(input logic [31:0] a, input int n);
    if (n == 0) return a;
    return (a >> n) | (a << (32 - n));
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] n,
                        input bit d, input bit hold);
    exp_t e, got;
    int   m, lat, bcnt;
    m = int'(n[4:0]);
    if (d) m = (32 - m) % 32;
    e.res = ror_model(a, m);
    e.lat = ror_pkg::ceil_div(m, STEP);
    sb.push_back(e);
    in = a;
    num_rotate = n;
    start = 1'b1;
`ifdef ROR32_SEQ_DIR_EN
    dir = d;
`endif
    tick;
    if (hold) begin
      in = ~a;
      num_rotate = 32'd5;
    end else begin
      start = 1'b0;
    end
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick;
      lat++;
    end
    if (busy) bcnt++;
    start = 1'b0;
    got = sb.pop_front();
    check({tag, "_out"}, out, got.res);
    check({tag, "_lat"}, 32'(lat), 32'(got.lat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(got.lat + 1));
    tick;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_out"}, out, got.res);
  endtask

  initial begin
    int seen;

    // Reset with start held high: reset must win.
    clear = 1'b1;
    start = 1'b1;
    in = 32'hFFFF_FFFF;
    num_rotate = 32'd3;
    tick;
    tick;
    check("rst_out", out, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    clear = 1'b0;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (done || busy) seen++;
    end
    check("rst_no_activity", 32'(seen), 32'd0);

    run_op("ror4",  32'h1234_5678, 32'd4,  1'b0, 1'b0);
    check("ror4_value", out, 32'h8123_4567);
    run_op("ror8",  32'h1234_5678, 32'd8,  1'b0, 1'b0);
    check("ror8_value", out, 32'h7812_3456);
    run_op("wrap36", 32'h1234_5678, 32'd36, 1'b0, 1'b0);
    check("wrap36_value", out, 32'h8123_4567);
    run_op("wrap32", 32'h1234_5678, 32'd32, 1'b0, 1'b0);
    check("wrap32_value", out, 32'h1234_5678);
    run_op("max31", 32'h8000_0000, 32'd31, 1'b0, 1'b1);
    check("max31_value", out, 32'h0000_0001);
    run_op("odd13", 32'hA5C3_0F96, 32'hFFFF_FFED, 1'b0, 1'b0);
    run_op("one1",  32'hDEAD_BEEF, 32'd1,  1'b0, 1'b0);

    // Clear on the second ROTATE edge discards the operation.
    in = 32'hDEAD_BEEF;
    num_rotate = 32'd20;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("midclr_out", out, 32'h0);
    check("midclr_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      tick;
    end
    check("midclr_no_done", 32'(seen), 32'd0);

`ifdef ROR32_SEQ_DIR_EN
    run_op("rol1", 32'h0000_0001, 32'd1, 1'b1, 1'b0);
    check("rol1_value", out, 32'h0000_0002);
    run_op("ror1", 32'h0000_0001, 32'd1, 1'b0, 1'b0);
    check("ror1_value", out, 32'h8000_0000);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ror32_seq.md
Name: ror32_seq

Overview:
- Sequential rotate-right unit for the CPU datapath; the counterpart to the combinational rotate-left block.
- Takes a 32-bit operand and a rotate count, and rotates in up to STEP bit positions per clock.
- Returns the result with a start/busy/done handshake.
- Sits beside the ALU and is driven by the control unit for ROR instructions; the multi-cycle latency is absorbed by control-unit stall states.

Parameters:
STEP, 4, max bit positions rotated per clock; legal 1..31; sizes the per-cycle rotator.
WIDTH, 32, operand width; fixed at 32 and not overridable in practice, kept for readability.

Ports:
clock  input  1  system clock; all state updates on rising edge.
clear  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
in  input  32  operand; captured on the accepting edge.
num_rotate  input  32  rotate count; only num_rotate[4:0] used (count mod 32); captured on the accepting edge.
out  output  32  result register; holds the last result until the next completion.
busy  output  1  high while state is not IDLE.
done  output  1  one-cycle pulse; out is valid in the same cycle.

Behaviour:
- Reset: clear high at a clock edge -> state=IDLE, out=0, busy=0, done=0, internal shift reg=0, remaining=0.
  - clear overrides start and any in-flight operation; the partial result is discarded.
- States: IDLE, ROTATE, DONE. busy = (state!=IDLE); done = (state==DONE).
- IDLE: on an edge with start=1:
  - shift reg <= in; rem <= num_rotate[4:0].
  - If rem==0: out <= in and go to DONE.
  - Otherwise go to ROTATE.
  - start=0 -> stay in IDLE.
- ROTATE: each edge:
  - k = min(rem, STEP); shift reg <= rotate-right(shift reg, k); rem <= rem-k.
  - If rem-k==0: out <= rotated value and go to DONE.
- DONE: lasts exactly one cycle, then goes to IDLE unconditionally.
- Rotate-right definition: out[i] = in[(i+n) mod 32].
- Latency: with start accepted at edge E0, done is high in the cycle after edge E_L, where L = ceil(n/STEP) and n = num_rotate mod 32.
  - n=0 gives L=0 (done in the cycle after E0).
  - Maximum L is ceil(31/STEP); 8 for STEP=4.
- Back-to-back: the earliest next accept is the edge that leaves DONE... no: start asserted during DONE is ignored. The next accept is the first edge in IDLE, so successive starts are at least L+2 edges apart.
- start asserted during ROTATE or DONE is ignored, never queued. in and num_rotate may change freely after the accepting edge.
- num_rotate >= 32 wraps (e.g. 36 -> 4, 32 -> 0). The upper 27 bits are ignored.
- clear and start high on the same edge -> reset wins.

Optional Feature:
- Macro: ROR32_SEQ_DIR_EN.
- Defined: adds port dir (input, 1 bit), captured with start. dir=1 selects rotate-left by loading rem = (32 - n) mod 32; dir=0 selects rotate-right. Latency follows the loaded rem.
- Not defined: no dir port; always rotate-right.

Decomposition:
- Package ror_pkg:
  - WIDTH=32, AMT_W=5.
  - State enum {IDLE, ROTATE, DONE}.
  - Function ceil_div for latency checks in the bench.
- One sub-module, ror_step: combinational rotate-right of a 32-bit word by a k in 0..STEP. It is instantiated once on the shift-reg path.

Test Plan:
- Reset: clear=1 for 2 cycles with start=1 -> out=0, busy=0, done=0, no done pulse afterwards.
- STEP=4, in=0x12345678, num_rotate=4 -> done one cycle after E1, out=0x81234567; num_rotate=8 -> out=0x78123456 after 2 rotate edges.
- Wrap: in=0x12345678, num_rotate=36 -> out=0x81234567 with L=1; num_rotate=32 -> out=0x12345678 with L=0.
- Max count: in=0x80000000, num_rotate=31, STEP=4 -> busy high for 9 cycles (8 ROTATE + 1 DONE), out=0x00000001; start pulses during busy are ignored and out is unchanged.
- Mid-operation clear: in=0xDEADBEEF, num_rotate=20, clear on the 2nd ROTATE edge -> next cycle state=IDLE, out=0, no done pulse.
- With ROR32_SEQ_DIR_EN: in=0x00000001, num_rotate=1, dir=1 -> out=0x00000002; dir=0 -> out=0x80000000.
